alu_issue_unit: RTL

//  Issue/writeback stage wrapped around the 16-bit ALU. Accepts one 16-bit instruction via

---
 rtl/alu_pkg.sv | 53 +++++
 rtl/alu_issue_unit_if.sv | 30 +++
 rtl/regfile_8x16.sv | 47 ++++
 rtl/alu_issue_unit.sv | 133 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback stage.
//   - data/register geometry (DW, NREG, RAW)
//   - opcode encodings OP_NOP..OP_CMP
//   - issue FSM state enum {IDLE, ISSUE, WB}
//   - instruction field bit positions and ALU status bit indices
//   - helpers deciding which architectural state an opcode commits
package alu_pkg;

    localparam int DW   = 16;
    localparam int NREG = 8;
    localparam int RAW  = 3;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_MOVB = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_CMP  = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } state_t;

    // Instruction layout: [15:13] op, [12:10] rd, [9:7] rs, [6:4] rt, [3:0] unused
    localparam int OP_MSB = 15;
    localparam int OP_LSB = 13;
    localparam int RD_MSB = 12;
    localparam int RD_LSB = 10;
    localparam int RS_MSB = 9;
    localparam int RS_LSB = 7;
    localparam int RT_MSB = 6;
    localparam int RT_LSB = 4;

    // ALU status word flag positions
    localparam int ST_Z = 15;
    localparam int ST_N = 14;
    localparam int ST_C = 13;
    localparam int ST_V = 12;

    function automatic logic op_writes_rd(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_MOVB) || (op == OP_SHL);
    endfunction

    function automatic logic op_writes_status(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
    endfunction

endpackage

// File: rtl/alu_issue_unit_if.sv
// Instruction handshake plus ALU operand/result bus of the issue unit.
//   instr_valid/instr/instr_ready : instruction handshake (producer -> unit)
//   alu_a/alu_b/alu_op            : registered operands/opcode (unit -> ALU)
//   alu_result/alu_hi/alu_low/alu_status : ALU outputs (ALU -> unit)
// Modports: slave = issue unit side, master = producer/ALU side.
interface alu_issue_unit_if;
    import alu_pkg::*;

    logic          instr_valid;
    logic [15:0]   instr;
    logic          instr_ready;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [2:0]    alu_op;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] alu_hi;
    logic [DW-1:0] alu_low;
    logic [DW-1:0] alu_status;

    modport slave (
        input  instr_valid, instr, alu_result, alu_hi, alu_low, alu_status,
        output instr_ready, alu_a, alu_b, alu_op
    );

    modport master (
        output instr_valid, instr, alu_result, alu_hi, alu_low, alu_status,
        input  instr_ready, alu_a, alu_b, alu_op
    );

endinterface

// File: rtl/regfile_8x16.sv
// 8 x 16 register file: two asynchronous read ports, one synchronous write
// port, r0 hardwired to zero, asynchronous active-low clear of all entries.
//   clk, rst_n       : clock, async active-low clear
//   ra0_i/rd0_o      : read port 0
//   ra1_i/rd1_o      : read port 1
//   we_i/wa_i/wd_i   : write port (writes to r0 dropped)
//   ra2_i/rd2_o      : extra read port, only with ALU_ISSUE_DBG_EN defined
module regfile_8x16
    import alu_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [RAW-1:0] ra0_i,
    output logic [DW-1:0]  rd0_o,
    input  logic [RAW-1:0] ra1_i,
    output logic [DW-1:0]  rd1_o,
    input  logic           we_i,
    input  logic [RAW-1:0] wa_i,
    input  logic [DW-1:0]  wd_i
`ifdef ALU_ISSUE_DBG_EN
    ,
    input  logic [RAW-1:0] ra2_i,
    output logic [DW-1:0]  rd2_o
`endif
);

    logic [DW-1:0] mem_q [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (wa_i != '0)) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    // Address 0 is forced to zero on the read side as well, so r0 stays zero
    // regardless of what the storage holds.
    assign rd0_o = (ra0_i == '0) ? '0 : mem_q[ra0_i];
    assign rd1_o = (ra1_i == '0) ? '0 : mem_q[ra1_i];
`ifdef ALU_ISSUE_DBG_EN
    assign rd2_o = (ra2_i == '0) ? '0 : mem_q[ra2_i];
`endif

endmodule

// File: rtl/alu_issue_unit.sv
// Issue/writeback stage around a 16-bit ALU. One instruction in flight,
// fixed 3-cycle occupancy: IDLE (accept, read operands) -> ISSUE (ALU
// settles) -> WB (commit result/HI/LO/STATUS, pulse done).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_issue_unit_if.slave (instruction handshake + ALU bus)
//   hi_q, lo_q : architectural HI/LO (written by MUL)
//   status_q   : architectural {Z,N,C,V} (written by ADD/SUB/CMP)
//   done       : one-cycle pulse while in WB
// Optional feature macro ALU_ISSUE_DBG_EN adds dbg_addr (in) / dbg_data (out),
// a side-effect-free combinational read of the register file.
module alu_issue_unit
    import alu_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    alu_issue_unit_if.slave bus,
    output logic [DW-1:0]  hi_q,
    output logic [DW-1:0]  lo_q,
    output logic [3:0]     status_q,
    output logic           done
`ifdef ALU_ISSUE_DBG_EN
    ,
    input  logic [RAW-1:0] dbg_addr,
    output logic [DW-1:0]  dbg_data
`endif
);

    state_t         state_q, state_d;
    logic [DW-1:0]  alu_a_q, alu_a_d;
    logic [DW-1:0]  alu_b_q, alu_b_d;
    logic [2:0]     alu_op_q, alu_op_d;
    logic [RAW-1:0] rd_q, rd_d;
    logic [DW-1:0]  hi_d, lo_d;
    logic [3:0]     status_d;
    logic           instr_ready;
    logic           rf_we;
    logic [DW-1:0]  rs_data, rt_data;

    // Operands are read straight from the incoming instruction so they can be
    // captured in the same cycle the instruction is accepted.
    regfile_8x16 u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .ra0_i (bus.instr[RS_MSB:RS_LSB]),
        .rd0_o (rs_data),
        .ra1_i (bus.instr[RT_MSB:RT_LSB]),
        .rd1_o (rt_data),
        .we_i  (rf_we),
        .wa_i  (rd_q),
        .wd_i  (bus.alu_result)
`ifdef ALU_ISSUE_DBG_EN
        ,
        .ra2_i (dbg_addr),
        .rd2_o (dbg_data)
`endif
    );

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rd_d        = rd_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        status_d    = status_q;
        instr_ready = 1'b0;
        rf_we       = 1'b0;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    state_d  = ISSUE;
                    alu_a_d  = rs_data;
                    alu_b_d  = rt_data;
                    alu_op_d = bus.instr[OP_MSB:OP_LSB];
                    rd_d     = bus.instr[RD_MSB:RD_LSB];
                end
            end
            ISSUE: begin
                state_d = WB;
            end
            WB: begin
                state_d = IDLE;
                done    = 1'b1;
                rf_we   = op_writes_rd(alu_op_q);
                if (op_writes_status(alu_op_q)) begin
                    status_d = bus.alu_status[ST_Z:ST_V];
                end
                if (alu_op_q == OP_MUL) begin
                    hi_d = bus.alu_hi;
                    lo_d = bus.alu_low;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= OP_NOP;
            rd_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            rd_q     <= rd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            status_q <= status_d;
        end
    end

    assign bus.instr_ready = instr_ready;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_op      = alu_op_q;

    // Instruction padding bits and the ALU's low status bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.instr[3:0], bus.alu_status[11:0]};

endmodule
